// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the hex display scanner
//
// Purpose: digit count, all-anodes-off pattern and the 2-bit digit-index type
// used by the scanner top level and its testbench.
package display_pkg;

   localparam int           NUM_DIGITS = 4;
   localparam logic [3:0]   AN_ALL_OFF = 4'b1111;

   typedef logic [1:0] digit_t;

endpackage

// File: rtl/hex_display_scanner_if.sv
// rtl/hex_display_scanner_if.sv - load strobe and display outputs of the hex scanner
//
// Purpose: bundles the value load strobe and the decoder/anode/status outputs.
// Signals:
//   load        strobe from the master, captures value
//   value[15:0] hex value, [3:0] is digit 0 (rightmost)
//   w,x,y,z     selected nibble to the seven-segment decoder, MSB w
//   an[3:0]     active-low digit anodes
//   pending     a loaded value waits for the next frame boundary
//   frame_done  one-cycle pulse after each frame boundary
// Modports: master drives load/value, slave (the scanner) drives the rest.
interface hex_display_scanner_if;

   logic        load;
   logic [15:0] value;
   logic        w;
   logic        x;
   logic        y;
   logic        z;
   logic [3:0]  an;
   logic        pending;
   logic        frame_done;

   modport master (
      output load, value,
      input  w, x, y, z, an, pending, frame_done
   );

   modport slave (
      input  load, value,
      output w, x, y, z, an, pending, frame_done
   );

endinterface

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running digit-dwell prescaler
//
// Purpose: counts 0..CLK_DIV-1 and wraps; tick marks the last count of a dwell.
// Parameters: CLK_DIV clock cycles per dwell (>= 2).
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset, counter returns to 0
//   tick     high while the counter holds CLK_DIV-1
module scan_prescaler #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int             CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_pcnt;

   assign tick = (r_pcnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pcnt <= '0;
      end else if (tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + CW'(1);
      end
   end

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - four-digit time-multiplexed hex display scan controller
//
// Purpose: scans a 16-bit hex value one nibble at a time onto the decoder
// inputs and drives the matching active-low anode. Loads are held in a pending
// register and committed only at a frame boundary, so a frame never mixes old
// and new digits. A load on the boundary cycle itself is committed directly.
// Parameters: CLK_DIV clock cycles per digit dwell (>= 2).
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      hex_display_scanner_if.slave (load/value in; w,x,y,z, an,
//            pending, frame_done out)
// Configuration: HEX_SCAN_BLANK_EN enables leading-zero blanking of digits 1..3.
module hex_display_scanner
   import display_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   hex_display_scanner_if.slave   bus
);

   localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

   logic        w_tick;
   logic        w_boundary;
   logic        w_blank;
   logic [3:0]  w_nib;
   logic [3:0]  w_an;

   digit_t      r_dig;
   logic [15:0] r_disp;
   logic [15:0] r_pend;
   logic        r_pend_v;
   logic [3:0]  r_nib;
   logic [3:0]  r_an;
   logic        r_frame_done;

   scan_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (w_tick)
   );

   assign w_boundary = w_tick && (r_dig == LAST_DIGIT);

`ifdef HEX_SCAN_BLANK_EN
   // A digit is dark when it and every more-significant nibble are zero;
   // digit 0 always stays lit so a zero value still shows "0".
   always_comb begin
      w_blank = 1'b0;
      case (r_dig)
         2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
         2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
         2'd3:    w_blank = (r_disp[15:12] == 4'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_nib = r_disp[{r_dig, 2'b00} +: 4];
   assign w_an  = w_blank ? AN_ALL_OFF : ~(4'b0001 << r_dig);

   // Digit index, commit logic and output registers. The commit and the
   // digit wrap share one edge, so digit 0 of the new frame shows new data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_dig        <= '0;
         r_disp       <= '0;
         r_pend       <= '0;
         r_pend_v     <= 1'b0;
         r_nib        <= '0;
         r_an         <= AN_ALL_OFF;
         r_frame_done <= 1'b0;
      end else begin
         if (w_tick) begin
            r_dig <= r_dig + digit_t'(1);
         end

         if (w_boundary) begin
            r_pend_v <= 1'b0;
            if (bus.load) begin
               r_disp <= bus.value;
            end else if (r_pend_v) begin
               r_disp <= r_pend;
            end
         end else if (bus.load) begin
            r_pend   <= bus.value;
            r_pend_v <= 1'b1;
         end

         r_nib        <= w_nib;
         r_an         <= w_an;
         r_frame_done <= w_boundary;
      end
   end

   assign bus.w          = r_nib[3];
   assign bus.x          = r_nib[2];
   assign bus.y          = r_nib[1];
   assign bus.z          = r_nib[0];
   assign bus.an         = r_an;
   assign bus.pending    = r_pend_v;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] nib;
   int         cyc;
   int         checks = 0;
   int         errors = 0;

   hex_display_scanner_if bus ();

   hex_display_scanner #(
      .CLK_DIV (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign nib = {bus.w, bus.x, bus.y, bus.z};

`ifdef HEX_SCAN_BLANK_EN
   localparam logic [3:0] AN_D1_BLANK = 4'b1111;
   localparam logic [3:0] AN_D2_BLANK = 4'b1111;
   localparam logic [3:0] AN_D3_BLANK = 4'b1111;
`else
   localparam logic [3:0] AN_D1_BLANK = 4'b1101;
   localparam logic [3:0] AN_D2_BLANK = 4'b1011;
   localparam logic [3:0] AN_D3_BLANK = 4'b0111;
`endif

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int k);
      while (cyc < k) step();
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.load  = 1'b1;
      bus.value = 16'hFFFF;
      cyc       = 0;
      repeat (3) step();
      check("rst_an", 16'(bus.an), 16'hF);
      check("rst_nib", 16'(nib), 16'h0);
      check("rst_pending", 16'(bus.pending), 16'h0);
      check("rst_fd", 16'(bus.frame_done), 16'h0);

      // cyc counts edges since reset release
      reset_n  = 1'b1;
      bus.load = 1'b0;
      cyc      = 0;
      step();
      check("first_an", 16'(bus.an), 16'hE);
      check("first_nib", 16'(nib), 16'h0);
      step_to(4);
      check("dwell_an4", 16'(bus.an), 16'hE);
      step_to(5);
      check("dwell_an5", 16'(bus.an), 16'hD);

      // deferred commit
      bus.load  = 1'b1;
      bus.value = 16'h1234;
      step();
      bus.load  = 1'b0;
      check("defer_pending", 16'(bus.pending), 16'h1);
      step_to(9);
      check("defer_old_an", 16'(bus.an), 16'hB);
      check("defer_old_nib", 16'(nib), 16'h0);
      step_to(16);
      check("defer_fd", 16'(bus.frame_done), 16'h1);
      check("defer_pend_clr", 16'(bus.pending), 16'h0);
      check("defer_last_old", 16'(nib), 16'h0);
      step_to(17);
      check("defer_fd_off", 16'(bus.frame_done), 16'h0);
      check("defer_d0", {8'(bus.an), 8'(nib)}, 16'h0E04);
      step_to(21);
      check("defer_d1", {8'(bus.an), 8'(nib)}, 16'h0D03);
      step_to(25);
      check("defer_d2", {8'(bus.an), 8'(nib)}, 16'h0B02);
      step_to(29);
      check("defer_d3", {8'(bus.an), 8'(nib)}, 16'h0701);

      // load on the boundary cycle (edge 32)
      step_to(31);
      bus.load  = 1'b1;
      bus.value = 16'hABCD;
      step();
      bus.load  = 1'b0;
      check("bnd_pending", 16'(bus.pending), 16'h0);
      check("bnd_fd", 16'(bus.frame_done), 16'h1);
      step();
      check("bnd_fd_once", 16'(bus.frame_done), 16'h0);
      check("bnd_d0", {8'(bus.an), 8'(nib)}, 16'h0E0D);

      // last load wins
      step_to(35);
      bus.load  = 1'b1;
      bus.value = 16'h1111;
      step();
      bus.value = 16'h2222;
      step();
      bus.load  = 1'b0;
      check("llw_pending", 16'(bus.pending), 16'h1);
      step_to(48);
      check("llw_fd", 16'(bus.frame_done), 16'h1);
      for (int k = 0; k < 4; k++) begin
         step_to(49 + 4 * k);
         check("llw_nib", 16'(nib), 16'h2);
      end

      // leading-zero blanking (expectations follow the build option)
      step_to(50);
      bus.load  = 1'b1;
      bus.value = 16'h0050;
      step();
      bus.load  = 1'b0;
      step_to(65);
      check("blk_d0", {8'(bus.an), 8'(nib)}, 16'h0E00);
      step_to(69);
      check("blk_d1", {8'(bus.an), 8'(nib)}, 16'h0D05);
      step_to(73);
      check("blk_d2", {8'(bus.an), 8'(nib)}, {8'(AN_D2_BLANK), 8'h00});
      step_to(77);
      check("blk_d3", {8'(bus.an), 8'(nib)}, {8'(AN_D3_BLANK), 8'h00});
      bus.load  = 1'b1;
      bus.value = 16'h0000;
      step();
      bus.load  = 1'b0;
      step_to(81);
      check("zero_d0", {8'(bus.an), 8'(nib)}, 16'h0E00);
      step_to(85);
      check("zero_d1", 16'(bus.an), 16'(AN_D1_BLANK));

      // reset mid-frame with a value pending
      step_to(87);
      bus.load  = 1'b1;
      bus.value = 16'h7777;
      step();
      bus.load  = 1'b0;
      check("mid_pending", 16'(bus.pending), 16'h1);
      step_to(90);
      reset_n = 1'b0;
      step();
      check("mid_rst_an", 16'(bus.an), 16'hF);
      check("mid_rst_pend", 16'(bus.pending), 16'h0);
      reset_n = 1'b1;
      cyc     = 0;
      step();
      check("mid_first", {8'(bus.an), 8'(nib)}, 16'h0E00);
      step_to(4);
      check("mid_dwell4", 16'(bus.an), 16'hE);
      step_to(5);
      check("mid_dwell5", 16'(bus.an), 16'hD);
      step_to(16);
      check("mid_fd", 16'(bus.frame_done), 16'h1);
      check("mid_pend0", 16'(bus.pending), 16'h0);
      step_to(17);
      check("mid_disp0", {8'(bus.an), 8'(nib)}, 16'h0E00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
